// File: rtl/encrypt_pipe_xor_rotate.sv
// rtl/encrypt_pipe_xor_rotate.sv - XOR with rotating three-key schedule and per-byte key rotation
// One-cycle registered stage; schedule restarts at k1/rot 0 whenever a message (en run) begins.
module encrypt_pipe_xor_rotate (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  output logic [7:0] data_out,
  output logic       en_out,
  output logic       mode_out,
  output logic [1:0] key_idx_out
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [1:0]  key_idx;
  logic [2:0]  rot_cnt;
  logic [2:0]  bit_rot;
  logic [2:0]  rf_lat;

  logic [1:0]  cur_idx;
  logic [2:0]  cur_rot;
  logic [2:0]  cur_cnt;
  logic [2:0]  rf_eff;
  logic [7:0]  k_sel;
  logic [15:0] k_dbl;
  logic [7:0]  k_rot;

  // In IDLE the schedule is by definition fresh; an illegal key_idx selects k1.
  always_comb begin
    cur_idx = 2'd0;
    cur_rot = 3'd0;
    cur_cnt = 3'd0;
    rf_eff  = rot_freq;
    if (state == ACTIVE) begin
      cur_idx = (key_idx == 2'd3) ? 2'd0 : key_idx;
      cur_rot = bit_rot;
      cur_cnt = rot_cnt;
      rf_eff  = rf_lat;
    end
    case (cur_idx)
      2'd1:    k_sel = k2;
      2'd2:    k_sel = k3;
      default: k_sel = k1;
    endcase
    k_dbl = {k_sel, k_sel} << cur_rot;
    k_rot = k_dbl[15:8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      key_idx     <= 2'd0;
      rot_cnt     <= 3'd0;
      bit_rot     <= 3'd0;
      rf_lat      <= 3'd0;
      data_out    <= 8'h00;
      en_out      <= 1'b0;
      mode_out    <= 1'b0;
      key_idx_out <= 2'd0;
    end else if (!en) begin
      state       <= IDLE;
      key_idx     <= 2'd0;
      rot_cnt     <= 3'd0;
      bit_rot     <= 3'd0;
      data_out    <= 8'h00;
      en_out      <= 1'b0;
      mode_out    <= mode;
      key_idx_out <= 2'd0;
    end else if (mode) begin
      state       <= ACTIVE;
      data_out    <= din ^ k_rot;
      en_out      <= 1'b1;
      mode_out    <= 1'b1;
      key_idx_out <= cur_idx;
      bit_rot     <= cur_rot + 3'd1;
      if (state == IDLE)
        rf_lat <= rot_freq;
      if (rf_eff == 3'd0) begin
        key_idx <= cur_idx;
        rot_cnt <= cur_cnt;
      end else if (cur_cnt == rf_eff - 3'd1) begin
        rot_cnt <= 3'd0;
        key_idx <= (cur_idx == 2'd2) ? 2'd0 : cur_idx + 2'd1;
      end else begin
        key_idx <= cur_idx;
        rot_cnt <= cur_cnt + 3'd1;
      end
    end else begin
      // Pass-through leaves the schedule untouched, including in IDLE.
      data_out    <= din;
      en_out      <= 1'b1;
      mode_out    <= 1'b0;
      key_idx_out <= 2'd0;
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_xor_rotate.sv
// tb/tb_encrypt_pipe_xor_rotate.sv - scoreboard bench for encrypt_pipe_xor_rotate
module tb_encrypt_pipe_xor_rotate;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] k1 = 8'h00;
  logic [7:0] k2 = 8'h00;
  logic [7:0] k3 = 8'h00;
  logic [2:0] rot_freq = 3'd0;
  logic [7:0] data_out;
  logic       en_out;
  logic       mode_out;
  logic [1:0] key_idx_out;

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic       mode;
    logic [1:0] key;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  encrypt_pipe_xor_rotate dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq),
    .data_out(data_out), .en_out(en_out), .mode_out(mode_out),
    .key_idx_out(key_idx_out)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (data_out !== e.data || en_out !== e.en || mode_out !== e.mode || key_idx_out !== e.key) begin
        n_err++;
        $display("FAIL vec%0d: got data=%02h en=%b mode=%b key=%0d, want data=%02h en=%b mode=%b key=%0d",
                 n_vec, data_out, en_out, mode_out, key_idx_out, e.data, e.en, e.mode, e.key);
      end
    end
  end

  task automatic drive(input logic e_en, input logic e_mode, input logic [7:0] e_din,
                       input logic [7:0] e_data, input logic [1:0] e_key);
    exp_t x;
    en   = e_en;
    mode = e_mode;
    din  = e_din;
    @(posedge clk);
    #1;
    x.data = e_en ? e_data : 8'h00;
    x.en   = e_en;
    x.mode = e_mode;
    x.key  = e_key;
    q.push_back(x);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({data_out, en_out, mode_out, key_idx_out} !== 12'h000) begin
      n_err++;
      $display("FAIL %s: got data=%02h en=%b mode=%b key=%0d, want all zero",
               name, data_out, en_out, mode_out, key_idx_out);
    end
  endtask

  initial begin
    logic [7:0] walk;
    #3;
    check_zero("reset_state");
    #9 rst = 1'b1;

    // Key rotation, rot_freq=2
    k1 = 8'h0F; k2 = 8'hF0; k3 = 8'h55; rot_freq = 3'd2;
    drive(1, 1, 8'h00, 8'h0F, 0);
    drive(1, 1, 8'h00, 8'h1E, 0);
    drive(1, 1, 8'h00, 8'hC3, 1);
    drive(1, 1, 8'h00, 8'h87, 1);
    drive(1, 1, 8'h00, 8'h55, 2);
    gap();

    // No key advance, bit_rot wraps after eight bytes
    k1 = 8'h01; rot_freq = 3'd0;
    walk = 8'h01;
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 8'h00, walk, 0);
      walk = {walk[6:0], walk[7]};
    end
    gap();

    // Pass-through, and nonzero din through the XOR path
    drive(1, 0, 8'hA5, 8'hA5, 0);
    k1 = 8'h0F; rot_freq = 3'd2;
    drive(1, 1, 8'hFF, 8'hF0, 0);
    gap();

    // Pass-through inside a stream freezes the schedule
    k1 = 8'h0F; k2 = 8'hF0; rot_freq = 3'd2;
    drive(1, 1, 8'h00, 8'h0F, 0);
    drive(1, 1, 8'h00, 8'h1E, 0);
    drive(1, 0, 8'h3C, 8'h3C, 0);
    drive(1, 1, 8'h00, 8'hC3, 1);
    gap();

    // en gap restarts the schedule
    k1 = 8'h11; k2 = 8'h22; rot_freq = 3'd1;
    drive(1, 1, 8'h00, 8'h11, 0);
    drive(1, 1, 8'h00, 8'h44, 1);
    gap();
    drive(1, 1, 8'h00, 8'h11, 0);
    gap();

    // rot_freq change mid-message is ignored
    k1 = 8'h0F; k2 = 8'hF0; k3 = 8'h55; rot_freq = 3'd2;
    drive(1, 1, 8'h00, 8'h0F, 0);
    rot_freq = 3'd1;
    drive(1, 1, 8'h00, 8'h1E, 0);
    drive(1, 1, 8'h00, 8'hC3, 1);
    drive(1, 1, 8'h00, 8'h87, 1);
    drive(1, 1, 8'h00, 8'h55, 2);
    gap();

    // Asynchronous reset mid-stream, then a fresh schedule
    rot_freq = 3'd1;
    drive(1, 1, 8'h00, 8'h0F, 0);
    drive(1, 1, 8'h00, 8'hE1, 1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_zero("async_reset");
    #1 rst = 1'b1;
    drive(1, 1, 8'h00, 8'h0F, 0);
    gap();

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encrypt_pipe_xor_rotate.md
# encrypt_pipe_xor_rotate

Pipeline stage directly downstream of the shift/scramble stage in the encrypt pipeline. It consumes the scrambled byte plus the forwarded keys, rotation frequency, mode and enable. It XORs each byte with a key drawn from a rotating three-key schedule, rotated left by a per-byte bit offset. Output is registered with one cycle of latency and feeds the encrypt pipeline output register.

## Interface
- No parameters; all widths fixed.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  byte valid from the upstream stage (its en_out).
- mode  input  1  1 = encrypt (XOR applied), 0 = pass-through.
- din  input  8  scrambled byte (upstream data_out).
- k1, k2, k3  input  8 each  schedule keys, used in order k1, k2, k3, k1, …
- rot_freq  input  3  encrypted bytes per key before the key index advances; 0 = never advance.
- data_out  output  8  registered result byte.
- en_out  output  1  registered en.
- mode_out  output  1  registered mode.
- key_idx_out  output  2  key index (0/1/2) applied to the byte now on data_out.

## Operation
- FSM with two states:
  - IDLE (reset state).
  - ACTIVE.
- IDLE -> ACTIVE when en=1 and mode=1.
  - On this transition, rot_freq is latched into rf_lat.
  - The first byte is processed in the same cycle with key_idx=0 and bit_rot=0.
- ACTIVE -> IDLE when en=0.
  - On entering IDLE, key_idx, rot_cnt and bit_rot are cleared to 0.
- ACTIVE with en=1, mode=0: stays ACTIVE. The byte passes through; schedule state is frozen.
- Internal state:
  - key_idx, 2 bits, values 0..2 only.
  - rot_cnt, 3 bits.
  - bit_rot, 3 bits.
  - rf_lat, 3 bits.
- Encrypted byte (en=1, mode=1):
  - k_sel = k1/k2/k3 for key_idx 0/1/2.
  - data_out <= din XOR rotl8(k_sel, bit_rot).
  - key_idx_out <= key_idx.
- Schedule update after each encrypted byte:
  - bit_rot <= bit_rot+1, mod 8; wraps 7 -> 0.
  - If rf_lat != 0 and rot_cnt == rf_lat-1: rot_cnt <= 0 and key_idx advances 0->1->2->0.
  - If rf_lat != 0 otherwise: rot_cnt <= rot_cnt+1.
  - If rf_lat == 0: key_idx and rot_cnt are held.
- Pass-through byte (en=1, mode=0): data_out <= din; key_idx_out <= 0.
- en=0: data_out <= 0, key_idx_out <= 0, en_out <= 0, mode_out <= mode.
- rot_freq changes while ACTIVE are ignored until the next IDLE->ACTIVE transition.

## Timing
- Latency: exactly 1 cycle from inputs to every output. Throughput is one byte per cycle, with no stalls.
- Reset (rst=0, asynchronous):
  - data_out=0x00, en_out=0, mode_out=0, key_idx_out=0.
  - FSM goes to IDLE; rot_cnt, bit_rot and rf_lat are cleared to 0.
- Reset asserted mid-message: outputs clear immediately, without waiting for clk.
- After rst is released, the next byte with en=1 and mode=1 starts a fresh schedule at key_idx=0, bit_rot=0.
- A single-cycle en=0 gap inside a stream ends the message. The next byte restarts at k1 with bit_rot=0.
- Simultaneous key advance and bit_rot wrap in the same cycle are independent and both take effect.
- key_idx never reaches 3. Any illegal value (e.g. from SEU) is forced back to 0 on the next encrypted byte.

## Test plan
- Key rotation: k1=0x0F, k2=0xF0, k3=0x55, rot_freq=2, five consecutive din=0x00 with en=1, mode=1.
  - data_out = 0x0F, 0x1E, 0xC3, 0x87, 0x55.
  - key_idx_out = 0, 0, 1, 1, 2.
  - Each output appears one cycle after its input.
- No advance with bit_rot wrap: rot_freq=0, k1=0x01, nine din=0x00.
  - data_out = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, 0x01.
  - key_idx_out = 0 throughout.
- Pass-through: mode=0, en=1, din=0xA5 -> data_out=0xA5, mode_out=0, key_idx_out=0.
- Pass-through inside an encrypt stream:
  - Setup: rot_freq=2, k1=0x0F, k2=0xF0, din=0x00 on every encrypted byte.
  - Stream: encrypt, encrypt, mode=0 byte, encrypt.
  - The fourth byte gives data_out=0xC3, i.e. the schedule did not advance on the pass-through byte.
- en gap restarts the schedule:
  - Setup: rot_freq=1, k1=0x11, k2=0x22, din=0x00.
  - Stream: two encrypted bytes, data_out = 0x11 then 0x44.
  - Then en=0 for one cycle: data_out=0x00, en_out=0.
  - Next byte gives data_out=0x11, key_idx_out=0.
- Reset mid-stream and rot_freq latching:
  - Assert rst=0 between clock edges during a stream: all outputs are 0 before the next clk edge.
  - Separately, changing rot_freq from 2 to 1 mid-message does not change the advance points of the running message.
